// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Pixel-side timing source for the video mixer. It divides clk_vid into a
//   one-cycle ce_pix strobe and runs horizontal and vertical position
//   counters. Each position is requested from a core-side pixel source one
//   pixel period ahead. Colour, sync and blank are then emitted together on
//   the next ce_pix strobe.
//
// Ports
//   clk_vid              video clock
//   reset                synchronous, active-high
//   ce_pix               pixel clock-enable, one clk_vid cycle wide
//   pix_req              requested position lies in the active area
//   pix_x / pix_y        requested column / line
//   pix_r/g/b            source colour for the requested position
//   HSync, VSync         positive sync pulses
//   HBlank, VBlank       positive blanking
//   R, G, B              output colour (zero while blanked)
//   new_frame            high for the output pixel at (0,0)
module video_timing_gen #(
  parameter int CE_DIV   = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk_vid,
  input  logic        reset,
  output logic        ce_pix,
  output logic        pix_req,
  output logic [11:0] pix_x,
  output logic [10:0] pix_y,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic        HSync,
  output logic        VSync,
  output logic        HBlank,
  output logic        VBlank,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        new_frame
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
  localparam logic [11:0]   H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [11:0]   H_ACT    = 12'(H_ACTIVE);
  localparam logic [10:0]   V_ACT    = 11'(V_ACTIVE);
  localparam logic [11:0]   HS_BEG   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0]   HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_div;
  logic          r_ce;
  logic [11:0]   r_hc;
  logic [10:0]   r_vc;
  logic          r_req_valid;
  logic          r_pix_req;
  logic [11:0]   r_pix_x;
  logic [10:0]   r_pix_y;
  logic          r_hsync, r_vsync, r_hblank, r_vblank, r_new_frame;
  logic [7:0]    r_r, r_g, r_b;

  logic w_h_wrap, w_v_wrap;
  logic w_req_active;
  logic w_hsync, w_vsync, w_hblank, w_vblank;

  assign w_h_wrap     = (r_hc == H_LAST);
  assign w_v_wrap     = (r_vc == V_LAST);
  assign w_req_active = (r_hc < H_ACT) && (r_vc < V_ACT);

  // Decode of the position currently held in the request registers.
  assign w_hblank = (r_pix_x >= H_ACT);
  assign w_vblank = (r_pix_y >= V_ACT);
  assign w_hsync  = (r_pix_x >= HS_BEG) && (r_pix_x < HS_END);
  assign w_vsync  = (r_pix_y >= VS_BEG) && (r_pix_y < VS_END);

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_div       <= '0;
      r_ce        <= 1'b0;
      r_hc        <= '0;
      r_vc        <= '0;
      r_req_valid <= 1'b0;
      r_pix_req   <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_hsync     <= 1'b0;
      r_vsync     <= 1'b0;
      r_hblank    <= 1'b0;
      r_vblank    <= 1'b0;
      r_new_frame <= 1'b0;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      r_ce  <= (r_div == DIV_LAST);

      if (r_ce) begin
        // Position counters
        if (w_h_wrap) begin
          r_hc <= '0;
          r_vc <= w_v_wrap ? '0 : r_vc + 1'b1;
        end else begin
          r_hc <= r_hc + 1'b1;
        end

        // Request stage: the source gets one full pixel period to answer
        r_pix_x     <= r_hc;
        r_pix_y     <= r_vc;
        r_pix_req   <= w_req_active;
        r_req_valid <= 1'b1;

        // Output stage: consumes the request issued on the previous strobe.
        // On the first strobe after reset there is no request yet, so the
        // outputs stay at zero.
        if (r_req_valid) begin
          r_r         <= r_pix_req ? pix_r : 8'h00;
          r_g         <= r_pix_req ? pix_g : 8'h00;
          r_b         <= r_pix_req ? pix_b : 8'h00;
          r_hblank    <= w_hblank;
          r_vblank    <= w_vblank;
          r_hsync     <= w_hsync;
          r_new_frame <= (r_pix_x == '0) && (r_pix_y == '0);
          // VSync edges are aligned to the start of a line
          if (r_pix_x == '0)
            r_vsync <= w_vsync;
        end
      end
    end
  end

  assign ce_pix    = r_ce;
  assign pix_req   = r_pix_req;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign HSync     = r_hsync;
  assign VSync     = r_vsync;
  assign HBlank    = r_hblank;
  assign VBlank    = r_vblank;
  assign R         = r_r;
  assign G         = r_g;
  assign B         = r_b;
  assign new_frame = r_new_frame;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen. Instance A uses the default 640x480
// timing with CE_DIV=4. Instance B uses a tiny 8x6 raster with CE_DIV=2 so
// that whole frames and the frame wrap can be checked within a short run.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- DUT A: defaults ----------------
  logic        rst_a, src_ff;
  logic        ce_a, req_a, hs_a, vs_a, hb_a, vb_a, nf_a;
  logic [11:0] px_a;
  logic [10:0] py_a;
  logic [7:0]  pr_a, pg_a, pb_a, r_a, g_a, b_a;

  assign pr_a = src_ff ? 8'hFF : px_a[7:0];
  assign pg_a = src_ff ? 8'hFF : py_a[7:0];
  assign pb_a = src_ff ? 8'hFF : 8'h5A;

  video_timing_gen u_a (
    .clk_vid(clk), .reset(rst_a), .ce_pix(ce_a), .pix_req(req_a),
    .pix_x(px_a), .pix_y(py_a), .pix_r(pr_a), .pix_g(pg_a), .pix_b(pb_a),
    .HSync(hs_a), .VSync(vs_a), .HBlank(hb_a), .VBlank(vb_a),
    .R(r_a), .G(g_a), .B(b_a), .new_frame(nf_a)
  );

  // ---------------- DUT B: tiny raster ----------------
  logic        rst_b;
  logic        ce_b, req_b, hs_b, vs_b, hb_b, vb_b, nf_b;
  logic [11:0] px_b;
  logic [10:0] py_b;
  logic [7:0]  r_b, g_b, b_b;

  video_timing_gen #(
    .CE_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_b (
    .clk_vid(clk), .reset(rst_b), .ce_pix(ce_b), .pix_req(req_b),
    .pix_x(px_b), .pix_y(py_b), .pix_r(px_b[7:0]), .pix_g(py_b[7:0]), .pix_b(8'h5A),
    .HSync(hs_b), .VSync(vs_b), .HBlank(hb_b), .VBlank(vb_b),
    .R(r_b), .G(g_b), .B(b_b), .new_frame(nf_b)
  );

  // Advance to just after the next ce edge of the selected instance.
  task automatic wait_ce(input int sel);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((sel == 0) ? ce_a : ce_b) begin
        @(posedge clk);
        #1;
        got = 1;
      end
    end
    if (!got) chk("ce_timeout", 64'd0, 64'd1);
  endtask

  // Expects reset to have just been released at a negedge. Leaves time just
  // after the ce edge that shows output pixel (0,0).
  task automatic startup_a();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("a_ce_cyc%0d", k + 1), 64'(ce_a), 64'((k == 3 || k == 7) ? 1 : 0));
      chk($sformatf("a_out0_cyc%0d", k + 1),
          64'({hs_a, vs_a, hb_a, vb_a, nf_a, r_a, g_a, b_a}), 64'd0);
      if (k == 4)
        chk("a_first_req", 64'({req_a, px_a, py_a}), 64'({1'b1, 12'd0, 11'd0}));
    end
    @(posedge clk);
    #1;
    chk("a_first_pix", 64'({hs_a, vs_a, hb_a, vb_a, nf_a, r_a, g_a, b_a}),
        64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h5A}));
  endtask

  initial begin
    int hs_cnt, hb_cnt, vb_cnt, nf_cnt, hs_first, hb_first, pos;
    logic [7:0] hb_pat, hs_pat;
    logic [5:0] vb_pat, vs_pat;
    hb_pat = 8'b1111_0000;
    hs_pat = 8'b0110_0000;
    vb_pat = 6'b111_000;
    vs_pat = 6'b010_000;

    rst_a = 1'b1; rst_b = 1'b1; src_ff = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    startup_a();

    // One full line at default timing, output x = 0..799
    hs_cnt = 0; hb_cnt = 0; vb_cnt = 0; nf_cnt = 0; hs_first = -1; hb_first = -1;
    for (int x = 0; x < 800; x++) begin
      if (x > 0) wait_ce(0);
      if (hs_a) begin hs_cnt++; if (hs_first < 0) hs_first = x; end
      if (hb_a) begin hb_cnt++; if (hb_first < 0) hb_first = x; end
      if (vb_a) vb_cnt++;
      if (nf_a) nf_cnt++;
    end
    chk("a_hsync_width", 64'(hs_cnt), 64'd96);
    chk("a_hsync_start", 64'(hs_first), 64'd656);
    chk("a_hblank_width", 64'(hb_cnt), 64'd160);
    chk("a_hblank_start", 64'(hb_first), 64'd640);
    chk("a_vblank_line0", 64'(vb_cnt), 64'd0);
    chk("a_newframe_line0", 64'(nf_cnt), 64'd1);
    wait_ce(0);  // output (0,1)
    chk("a_line1_start", 64'({hs_a, hb_a, nf_a, r_a, g_a}), 64'({1'b0, 1'b0, 1'b0, 8'h00, 8'h01}));
    pos = 800;

    while (pos < 5 * 800 + 37) begin wait_ce(0); pos++; end
    chk("a_rgb_37_5", 64'({r_a, g_a, b_a}), 64'(24'h25055A));

    src_ff = 1'b1;
    while (pos < 5 * 800 + 700) begin wait_ce(0); pos++; end
    chk("a_blank_rgb", 64'({hb_a, r_a, g_a, b_a}), 64'({1'b1, 24'h000000}));
    src_ff = 1'b0;

    // Mid-frame reset for a single cycle
    while (pos < 6 * 800 + 300) begin wait_ce(0); pos++; end
    chk("a_pre_reset_rgb", 64'({r_a, g_a}), 64'(16'h2C06));
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    chk("a_reset_all0",
        64'({ce_a, req_a, px_a, py_a, hs_a, vs_a, hb_a, vb_a, nf_a, r_a, g_a, b_a}), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    startup_a();

    // Tiny raster: 8 pixels x 6 lines, CE_DIV=2
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk); #1;
    chk("b_ce_cyc1", 64'(ce_b), 64'd0);
    @(posedge clk); #1;
    chk("b_ce_cyc2", 64'(ce_b), 64'd1);
    wait_ce(1);
    chk("b_first_edge_out0", 64'({hs_b, vs_b, hb_b, vb_b, nf_b, r_b, g_b, b_b}), 64'd0);
    wait_ce(1);
    for (int i = 0; i < 96; i++) begin
      int x, y;
      bit act;
      if (i > 0) wait_ce(1);
      x = i % 8;
      y = (i / 8) % 6;
      act = (x < 4) && (y < 3);
      chk($sformatf("b_pix_%0d_%0d_f%0d", x, y, i / 48),
          64'({hs_b, vs_b, hb_b, vb_b, nf_b, r_b, g_b, b_b}),
          64'({hs_pat[x], vs_pat[y], hb_pat[x], vb_pat[y], (x == 0 && y == 0),
               act ? 8'(x) : 8'h00, act ? 8'(y) : 8'h00, act ? 8'h5A : 8'h00}));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
